// File: rtl/pipe_reg.sv
// pipe_reg -- elastic pipeline register with valid/ready handshake on both ends.
//
// A chain of DEPTH stages, each holding a valid bit and a WL-bit data word.
// Stage 0 faces the input port, stage DEPTH-1 drives the output port.
// Backpressure ripples combinationally from out_ready toward in_ready. Empty
// stages never block, so bubbles are squeezed out even while the output is
// stalled. flush drops every in-flight beat without touching the data
// registers. rst clears everything.
//
// Ports:
//   clk        posedge clock
//   rst        synchronous active-high reset (clears valid and data)
//   flush      synchronous clear of all valid bits
//   in_valid   upstream beat present
//   in_data    upstream beat, WL bits
//   in_ready   pipe accepts the beat this cycle
//   out_valid  stage DEPTH-1 holds a beat
//   out_data   data held in stage DEPTH-1
//   out_ready  downstream accepts this cycle
//   count      number of valid stages, 0..DEPTH

// One pipeline stage: EMPTY <-> FULL, driven by its ready term and the
// upstream valid bit.
//
// Ports:
//   clk, rst, flush  as in pipe_reg
//   ready            this stage may load from upstream this cycle
//   up_valid         valid bit of the upstream neighbour (or in_valid)
//   up_data          data of the upstream neighbour (or in_data)
//   valid            this stage's valid register
//   data             this stage's data register
module pipe_reg_stage #(
    parameter int WL = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          ready,
    input  logic          up_valid,
    input  logic [WL-1:0] up_data,
    output logic          valid,
    output logic [WL-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            // flush only kills the valid bits; the data words are left alone
            if (flush)
                valid <= 1'b0;
            else if (ready)
                valid <= up_valid;

            // Load data only when a real beat arrives, so an empty upstream
            // does not overwrite what this stage is holding.
            if (!flush && ready && up_valid)
                data <= up_data;
        end
    end

endmodule

module pipe_reg #(
    parameter int WL    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [WL-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [WL-1:0] out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0]         v;
    logic [DEPTH-1:0][WL-1:0] d;
    logic [DEPTH:0]           rdy;

    // Ready chain: a stage can load if it is empty or its successor can load.
    // Computed in one block so the ripple from out_ready is a single
    // combinational path of up to DEPTH gates with no skid register.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--)
            rdy[k] = ~v[k] | rdy[k+1];
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          up_v;
        logic [WL-1:0] up_d;

        if (k == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = v[k-1];
            assign up_d = d[k-1];
        end

        pipe_reg_stage #(.WL(WL)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .ready    (rdy[k]),
            .up_valid (up_v),
            .up_data  (up_d),
            .valid    (v[k]),
            .data     (d[k])
        );
    end

    assign in_ready  = rdy[0] & ~rst;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // Occupancy is a popcount of the valid registers only, so it never
    // depends combinationally on the handshake inputs.
    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++)
            count = count + CW'(v[k]);
    end

endmodule

// File: tb/tb_pipe_reg.sv
module tb_pipe_reg;

    localparam int D = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b1;
    logic [W-1:0] in_data = 16'hFFFF;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic [2:0]   count;

    // second instance: single-stage, single-bit degenerate case
    logic         flush1 = 1'b0;
    logic         in_valid1 = 1'b0;
    logic [0:0]   in_data1 = 1'b0;
    logic         in_ready1;
    logic         out_valid1;
    logic [0:0]   out_data1;
    logic         out_ready1 = 1'b1;
    logic [0:0]   count1;

    always #5 clk = ~clk;

    pipe_reg #(.WL(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count)
    );

    pipe_reg #(.WL(1), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
        .count(count1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: positions of in-flight beats (oldest first) and the
    // scoreboard of data words still owed to the downstream side.
    int           pos_q[$];
    logic [W-1:0] sb[$];
    bit           beef_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the negedge, check handshake/occupancy, then
    // advance the model at the posedge.
    task automatic cycle(input bit iv, input logic [W-1:0] id, input bit ordy,
                         input bit fl, input bit rs, output bit acc);
        bit exp_ir, exp_ov, pop;
        int lim;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        exp_ir = !rs && (ordy || pos_q.size() < D);
        exp_ov = pos_q.size() > 0 && pos_q[0] == D - 1;
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("count", 32'(count), 32'(pos_q.size()));
        acc = 0;
        @(posedge clk);
        if (rs) begin
            pos_q.delete();
            sb.delete();
        end else begin
            pop = exp_ov && ordy;
            if (pop) void'(pos_q.pop_front());
            // every beat moves one step forward unless the beat ahead blocks it
            lim = D;
            foreach (pos_q[i]) begin
                int p;
                p = pos_q[i] + 1;
                if (p > lim - 1) p = lim - 1;
                pos_q[i] = p;
                lim = p;
            end
            if (fl) begin
                pos_q.delete();
                sb.delete();
            end else if (iv && exp_ir) begin
                pos_q.push_back(0);
                sb.push_back(id);
                acc = 1;
            end
        end
    endtask

    // Monitor: compares each output transfer against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (out_data == 16'hBEEF) beef_seen = 1;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL out_data: unexpected beat %h, none expected at %0t", out_data, $time);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic idle(input int n, input bit ordy);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, ordy, 1'b0, 1'b0, a);
    endtask

    initial begin
        bit a;
        int k;
        logic [0:0] prev1;

        // reset held with a beat presented
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, a);
        #2 chk("rst_out_data", 32'(out_data), 32'h0);
        idle(1, 1'b0); // in_ready must be 1 in the first cycle after release

        // streaming back to back
        for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b1, 1'b0, 1'b0, a);
        idle(6, 1'b1);

        // backpressure until stall, then release with in_valid held
        k = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 16'hA000 + 16'(k), 1'b0, 1'b0, 1'b0, a);
            if (a) k++;
        end
        chk("bp_accepted", 32'(k), 32'(D));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'hA000 + 16'(k), 1'b1, 1'b0, 1'b0, a);
            if (a) k++;
        end
        idle(D + 2, 1'b1);

        // bubble collapse
        cycle(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, a);
        idle(2, 1'b0);
        cycle(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, a);
        idle(4, 1'b0);
        chk("bubble_count", 32'(count), 32'd2);
        idle(4, 1'b1);

        // flush mid-stream with a beat offered in the same cycle
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, a);
        idle(D + 2, 1'b1);
        chk("flush_beef", 32'(beef_seen), 32'd0);

        // reset mid-stream together with flush
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0D00 + 16'(i), 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, a);
        #2 chk("midrst_out_data", 32'(out_data), 32'h0);
        cycle(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0, a);
        idle(D + 2, 1'b1);

        // DEPTH=1, WL=1 streaming: output equals last cycle's input
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid1 = 1'b1;
            in_data1  = 1'($urandom_range(0, 1));
            #1;
            chk("d1_in_ready", 32'(in_ready1), 32'd1);
            if (i > 0) begin
                chk("d1_out_valid", 32'(out_valid1), 32'd1);
                chk("d1_out_data", 32'(out_data1), 32'(prev1));
            end
            prev1 = in_data1;
        end
        @(negedge clk);
        in_valid1 = 1'b0;

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 99) == 0), a);
        end
        idle(D + 2, 1'b1);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
